// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - write-back queue from ALU/memory producers to the register file write port
// In-order result queue with fixed memory priority, one drain per cycle and a bypass lookup.
module regfile_wb_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_wa,
  input  logic [DW-1:0] alu_wd,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_wa,
  input  logic [DW-1:0] mem_wd,
  input  logic          rf_stall,
  output logic          regwrite,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd,
  output logic          memtoreg,
  input  logic [AW-1:0] q_ra,
  output logic          q_hit,
  output logic [DW-1:0] q_data,
  output logic [AW:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] ent_wa_q  [DEPTH];
  logic [DW-1:0] ent_wd_q  [DEPTH];
  logic          ent_src_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          regwrite_q;
  logic [AW-1:0] wa_q;
  logic [DW-1:0] wd_q;
  logic          memtoreg_q;

  logic          not_full;
  logic          mem_hs, alu_hs;
  logic [AW-1:0] push_wa;
  logic [DW-1:0] push_wd;
  logic          push, pop;
  logic [PW-1:0] byp_idx;

  assign not_full  = count_q < CW'(DEPTH);
  assign mem_ready = not_full;
  assign alu_ready = not_full & ~mem_valid;

  assign mem_hs  = mem_valid & mem_ready;
  assign alu_hs  = alu_valid & alu_ready;
  assign push_wa = mem_hs ? mem_wa : alu_wa;
  assign push_wd = mem_hs ? mem_wd : alu_wd;
  // Writes to register 0 complete their handshake but never occupy a slot.
  assign push    = (mem_hs | alu_hs) && (push_wa != '0);
  assign pop     = ~rf_stall && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_wa_q[wr_ptr_q]  <= push_wa;
      ent_wd_q[wr_ptr_q]  <= push_wd;
      ent_src_q[wr_ptr_q] <= mem_hs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      memtoreg_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (pop) begin
        regwrite_q <= 1'b1;
        wa_q       <= ent_wa_q[rd_ptr_q];
        wd_q       <= ent_wd_q[rd_ptr_q];
        memtoreg_q <= ent_src_q[rd_ptr_q];
      end else begin
        regwrite_q <= 1'b0;
      end
    end
  end

  // Scan oldest to newest so the last match seen is the newest pending value.
  always_comb begin
    q_hit   = 1'b0;
    q_data  = '0;
    byp_idx = '0;
    if (regwrite_q && (wa_q == q_ra)) begin
      q_hit  = 1'b1;
      q_data = wd_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      byp_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (ent_wa_q[byp_idx] == q_ra)) begin
        q_hit  = 1'b1;
        q_data = ent_wd_q[byp_idx];
      end
    end
    if (q_ra == '0) begin
      q_hit  = 1'b0;
      q_data = '0;
    end
  end

  assign regwrite = regwrite_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign memtoreg = memtoreg_q;
  assign count    = count_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - self-checking bench for regfile_wb_ctrl
// Queue-based reference model, per-cycle compare process, directed and random stimulus.
module tb_regfile_wb_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_valid, alu_ready, mem_valid, mem_ready;
  logic [2:0] alu_wa, mem_wa, wa, q_ra;
  logic [7:0] alu_wd, mem_wd, wd, q_data;
  logic       rf_stall, regwrite, memtoreg, q_hit;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  regfile_wb_ctrl #(.DW(8), .AW(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .rf_stall(rf_stall), .regwrite(regwrite), .wa(wa), .wd(wd), .memtoreg(memtoreg),
    .q_ra(q_ra), .q_hit(q_hit), .q_data(q_data), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] wa;
    logic [7:0] wd;
    logic       src;
  } ent_t;

  ent_t       mq[$];
  logic       m_rw  = 1'b0;
  logic [2:0] m_wa  = '0;
  logic [7:0] m_wd  = '0;
  logic       m_mtr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_rw = 1'b0; m_wa = '0; m_wd = '0; m_mtr = 1'b0;
    end else begin
      bit   full;
      ent_t e;
      full = (mq.size() >= 4);
      if (!rf_stall && mq.size() > 0) begin
        e = mq.pop_front();
        m_rw = 1'b1; m_wa = e.wa; m_wd = e.wd; m_mtr = e.src;
      end else begin
        m_rw = 1'b0;
      end
      if (!full) begin
        if (mem_valid) begin
          if (mem_wa != 0) mq.push_back('{wa: mem_wa, wd: mem_wd, src: 1'b1});
        end else if (alu_valid) begin
          if (alu_wa != 0) mq.push_back('{wa: alu_wa, wd: alu_wd, src: 1'b0});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit         full, hit;
      logic [7:0] data;
      full = (mq.size() >= 4);
      hit = 1'b0; data = '0;
      if (m_rw && m_wa == q_ra) begin hit = 1'b1; data = m_wd; end
      foreach (mq[i]) if (mq[i].wa == q_ra) begin hit = 1'b1; data = mq[i].wd; end
      if (q_ra == 0) begin hit = 1'b0; data = '0; end
      chk("mem_ready", mem_ready, !full);
      chk("alu_ready", alu_ready, !full && !mem_valid);
      chk("count", count, mq.size());
      chk("regwrite", regwrite, m_rw);
      chk("wa", wa, m_wa);
      chk("wd", wd, m_wd);
      chk("memtoreg", memtoreg, m_mtr);
      chk("q_hit", q_hit, hit);
      chk("q_data", q_data, data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [2:0] a, input logic [7:0] d);
    alu_valid = v; alu_wa = a; alu_wd = d;
  endtask

  initial begin
    rst_n = 1'b1;
    alu_valid = 0; alu_wa = 0; alu_wd = 0;
    mem_valid = 0; mem_wa = 0; mem_wd = 0;
    rf_stall = 0; q_ra = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_regwrite", regwrite, 0);
    chk("rst_count", count, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);

    // single ALU push
    alu(1, 3'd3, 8'h2D);
    tick();
    alu(0, 0, 0);
    chk("t1_count_after_push", count, 1);
    chk("t1_no_write_yet", regwrite, 0);
    tick();
    chk("t1_regwrite", regwrite, 1);
    chk("t1_wa", wa, 3);
    chk("t1_wd", wd, 8'h2D);
    chk("t1_memtoreg", memtoreg, 0);
    chk("t1_count_drained", count, 0);
    tick();
    chk("t1_regwrite_low", regwrite, 0);

    // memory priority
    mem_valid = 1; mem_wa = 3'd5; mem_wd = 8'h11;
    alu(1, 3'd6, 8'h22);
    #1;
    chk("t2_alu_blocked", alu_ready, 0);
    chk("t2_mem_ready", mem_ready, 1);
    tick();
    mem_valid = 0;
    tick();
    alu(0, 0, 0);
    chk("t2_first_wa", wa, 5);
    chk("t2_first_src", memtoreg, 1);
    tick();
    chk("t2_second_wa", wa, 6);
    chk("t2_second_src", memtoreg, 0);
    chk("t2_second_rw", regwrite, 1);
    tick();

    // fill while stalled, then drain
    rf_stall = 1;
    for (int i = 0; i < 5; i++) begin
      alu(1, 3'(i + 1), 8'(8'h40 + i));
      tick();
    end
    chk("t3_full_count", count, 4);
    chk("t3_full_alu_ready", alu_ready, 0);
    alu(0, 0, 0);
    rf_stall = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_drain_rw", regwrite, 1);
      chk("t3_drain_wa", wa, 32'(k + 1));
      chk("t3_drain_wd", wd, 32'(8'h40 + k));
    end
    chk("t3_empty", count, 0);
    tick();
    chk("t3_idle", regwrite, 0);

    // register 0 is dropped
    alu(1, 3'd0, 8'hFF);
    #1;
    chk("t4_ready", alu_ready, 1);
    tick();
    alu(0, 0, 0);
    chk("t4_count", count, 0);
    tick();
    chk("t4_no_write", regwrite, 0);

    // bypass newest match
    rf_stall = 1;
    alu(1, 3'd2, 8'h10); tick();
    alu(1, 3'd2, 8'h20); tick();
    alu(0, 0, 0);
    q_ra = 3'd2; #1;
    chk("t5_hit", q_hit, 1);
    chk("t5_data", q_data, 8'h20);
    q_ra = 3'd4; #1;
    chk("t5_miss", q_hit, 0);
    q_ra = 3'd0; #1;
    chk("t5_r0", q_hit, 0);

    // asynchronous reset mid-operation
    alu(1, 3'd7, 8'h33); tick();
    rf_stall = 0;
    alu(1, 3'd1, 8'h44); tick();
    alu(0, 0, 0);
    chk("t6_pre_count", count, 3);
    chk("t6_pre_rw", regwrite, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_rw", regwrite, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_wa", wa, 0);
    chk("t6_rst_wd", wd, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("t6_post_rw", regwrite, 0);
      chk("t6_post_count", count, 0);
    end

    // random traffic
    for (int n = 0; n < 600; n++) begin
      mem_valid = ($urandom_range(0, 3) == 0);
      mem_wa    = 3'($urandom_range(0, 7));
      mem_wd    = 8'($urandom);
      alu_valid = ($urandom_range(0, 1) == 0);
      alu_wa    = 3'($urandom_range(0, 7));
      alu_wd    = 8'($urandom);
      rf_stall  = ($urandom_range(0, 9) < 4);
      q_ra      = 3'($urandom_range(0, 7));
      tick();
    end
    mem_valid = 0; alu_valid = 0; rf_stall = 0;
    repeat (6) tick();
    chk("final_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-back controller feeding the register file write port (regwrite, wa, wd, memtoreg).
- Accepts results from two producers, the ALU path and the memory path, through valid/ready handshakes.
- Buffers accepted results in a small in-order queue and drains one register write per cycle.
- Exposes a bypass lookup so readers see pending, not-yet-written values.

Parameters:
- DW, 8, data width of wd and producer data.
- AW, 3, register address width (2^AW registers).
- DEPTH, 4, queue entries (power of 2, at least 2).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this edge when high together with alu_valid
- alu_wa  in  AW  ALU destination register
- alu_wd  in  DW  ALU result
- mem_valid  in  1  memory load result offered
- mem_ready  out  1  memory result accepted this edge when high together with mem_valid
- mem_wa  in  AW  load destination register
- mem_wd  in  DW  load data
- rf_stall  in  1  register file busy; hold the drain
- regwrite  out  1  register file write enable (registered)
- wa  out  AW  write address (registered)
- wd  out  DW  write data (registered)
- memtoreg  out  1  1 = current write sourced from memory path (registered)
- q_ra  in  AW  bypass lookup address
- q_hit  out  1  pending write to q_ra exists (combinational)
- q_data  out  DW  newest pending data for q_ra (combinational)
- count  out  AW+1  occupied queue entries

Behaviour:
- Reset (rst_n low, asynchronous): queue emptied, pointers 0, count 0.
- Reset values of registered outputs: regwrite 0, wa 0, wd 0, memtoreg 0.
- Reset values of combinational outputs: q_hit 0, q_data 0, alu_ready and mem_ready high once count is 0.
- Reset mid-operation discards all queued and in-flight writes; nothing is written after rst_n rises until new pushes arrive.
- Ready: mem_ready = (count < DEPTH). alu_ready = (count < DEPTH) and not mem_valid.
  - Memory has fixed priority; at most one push per edge.
  - Ready does not account for a same-edge pop; a full queue refuses input for that cycle.
- Push: on an edge with a valid&ready handshake, {wa, wd, src} is written at the write pointer.
  - src = 1 for the memory path, 0 for the ALU path.
  - Write pointer increments modulo DEPTH.
- Address-0 drop: a handshake with wa == 0 completes (ready honoured) but is not enqueued. Register 0 is never written.
- Drain: on each edge with rf_stall = 0 and count > 0:
  - regwrite <= 1; wa/wd/memtoreg <= head entry; read pointer increments.
  - Otherwise regwrite <= 0 and wa/wd/memtoreg hold their values.
- Latency: a result accepted at edge N into an empty queue with no stall drives regwrite high from edge N+1 to edge N+2.
- Ordering: strictly in acceptance order. Back-to-back pushes produce back-to-back regwrite pulses.
- Simultaneous push and pop: count unchanged. Push only: count+1. Pop only: count-1.
- Stall: asserting rf_stall drops regwrite at the next edge. The queue keeps filling until full.
- Bypass lookup: search every valid queue entry, plus the output register while regwrite is 1, for wa == q_ra.
  - Newest match wins (queue tail is newest, output register is oldest).
  - q_ra == 0 always gives q_hit 0 and q_data 0.
  - No match gives q_hit 0 and q_data 0.

Test Plan:
- Reset then single ALU push (wa=3, wd=0x2D) at edge 1 -> regwrite=1, wa=3, wd=0x2D, memtoreg=0 after edge 2; regwrite=0 after edge 3; count back to 0.
- Same edge: mem_valid (wa=5, wd=0x11) and alu_valid (wa=6, wd=0x22) -> mem accepted, alu_ready=0. ALU held valid is accepted next edge. Writes occur in order 5 then 6, memtoreg 1 then 0.
- rf_stall=1 while pushing 5 ALU results -> first 4 accepted, alu_ready=0 with count=4. Release stall -> 4 consecutive regwrite pulses in push order, count reaches 0.
- Push wa=0, wd=0xFF -> handshake completes, count stays 0, no regwrite.
- Queue holds wa=2 (0x10) then wa=2 (0x20) while stalled; q_ra=2 -> q_hit=1, q_data=0x20. q_ra=4 -> q_hit=0.
- rst_n pulsed low asynchronously with 3 entries queued -> regwrite, count, wa and wd go to 0 immediately. No writes occur after release.
